register_file_sb: RTL and testbench
===================================

// Module: register_file_sb
// PURPOSE
//  Parametrised integer register file for the pipelined core, successor to the fixed 32x32 2-read bank.
//  Configurable width, depth, read-port count and read latency, plus optional hardwired-zero register.
//  Same-cycle write-to-read forwarding and a per-register busy scoreboard, so decode can stall on pending writes.
//  Sits between decode (read/issue) and writeback (write).
// PARAMETERS
//  XLEN       32  data width of each register
//  NREGS      32  number of architectural registers (power of 2, >=2)
//  NREAD      2   number of independent read ports (1..4)
//  ZERO_REG   1   1: register 0 reads 0, ignores writes and issue; 0: register 0 is ordinary
//  SYNC_READ  0   0: combinational read; 1: registered read, 1-cycle latency
// PORTS  (AW = $clog2(NREGS))
//  clk         in   1           rising-edge clock
//  rst         in   1           asynchronous active-high reset
//  data_in     in   XLEN        writeback data
//  sel_in      in   AW          writeback register index
//  load_en     in   1           writeback enable
//  issue_en    in   1           decode issued an instruction that will write issue_sel
//  issue_sel   in   AW          destination index being claimed
//  sel_out     in   NREAD*AW    read indices, port p = sel_out[p*AW +: AW]
//  data_out    out  NREAD*XLEN  read data, port p = data_out[p*XLEN +: XLEN]
//  busy_out    out  NREAD       port p selects a register with a pending write
//  stall       out  1           OR of busy_out
// BEHAVIOUR
//  Reset (async, rst=1): all registers = 0 and all busy bits = 0.
//   With SYNC_READ=1, the data_out/busy_out registers = 0; outputs therefore read 0 during reset.
//  Write: at posedge, if load_en and !(ZERO_REG && sel_in==0), reg[sel_in] <= data_in.
//  Read value v(p):
//   - 0 if ZERO_REG && sel_out_p==0.
//   - Otherwise data_in if load_en && sel_in==sel_out_p (forwarding; new value visible in same cycle).
//   - Otherwise reg[sel_out_p].
//   - SYNC_READ=0: data_out_p = v(p) combinationally.
//   - SYNC_READ=1: data_out_p <= v(p) at posedge, so the value follows sel_out by exactly one cycle.
//  Scoreboard, busy[NREGS], updated at posedge:
//   - Clear: load_en clears busy[sel_in].
//   - Set: issue_en sets busy[issue_sel]; set has priority when issue_sel==sel_in in the same cycle (busy stays 1).
//   - ZERO_REG=1: busy[0] is constant 0; issue and write to index 0 are ignored.
//   - Issue to an already-busy register keeps it busy. No counting: a single later write clears it.
//  busy_out_p = busy[sel_out_p] && !(load_en && sel_in==sel_out_p), i.e. a write landing this cycle unblocks the read.
//   - SYNC_READ=1: busy_out_p is registered alongside data_out_p, same 1-cycle latency.
//   - stall = |busy_out, with no extra latency beyond busy_out.
//  Read ports are fully independent; any ports may select the same index.
//  Out-of-range indices cannot occur (NREGS is a power of 2).
//  rst asserted mid-operation clears busy bits, aborting all pending claims.
// STRUCTURE
//  Storage: generate loop of the existing `register #(.SIZE(XLEN))` sub-module, one instance per index.
//   - Index 0 is skipped when ZERO_REG=1.
//   - Instance load_en = load_en && sel_in==i.
//  Read muxes: generate loop over NREAD using an indexed array, not a hand-written case.
//  Scoreboard: a single always_ff on a NREGS-bit vector with async reset.
//  Shared package regfile_pkg: function addr_w(n) returning $clog2(n), and localparam REG_ZERO = 0.
// TESTING
//  1. Reset, then read all indices on every port -> data_out 0 and busy_out 0 for all.
//  2. Write reg5=32'hDEADBEEF; next cycle read port0=5, port1=0 -> 32'hDEADBEEF and 0 (ZERO_REG=1).
//   - Write reg0=32'h1234 -> reg0 still reads 0.
//  3. Write reg7=32'hA5A5A5A5 while port1 reads 7 in the same cycle -> SYNC_READ=0: data_out_1 equals it in that cycle.
//   - SYNC_READ=1: data_out_1 equals it in the following cycle.
//  4. issue_en with issue_sel=3, then read 3 -> busy_out=1 and stall=1 until writeback load_en with sel_in=3.
//   - In the writeback cycle busy_out=0 (combinational case).
//  5. Same cycle: issue_sel=9 and sel_in=9 with load_en -> reg9 updated and busy[9] remains 1 afterwards.
//  6. With busy[4]=1, pulse rst mid-cycle -> busy_out and stall drop to 0 immediately, registers read 0.
//   - Sweep NREAD=4, NREGS=16, XLEN=64.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and its storage cells.
package regfile_pkg;

  // Index of the register that is hardwired to zero when that option is on.
  localparam int REG_ZERO = 0;

  // Index width needed to address n registers (at least one bit).
  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/register_file_sb_register.sv
// Single storage register: loads data_in on load_en, clears on async reset.
module register #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_en,
  input  logic [SIZE-1:0] data_in,
  output logic [SIZE-1:0] data_out
);

  logic [SIZE-1:0] val_q;
  logic [SIZE-1:0] val_d;

  // Hold the current value unless a load is requested.
  always_comb begin
    val_d = val_q;
    if (load_en) val_d = data_in;
  end

  // Storage flop, cleared by the core reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) val_q <= '0;
    else     val_q <= val_d;
  end

  assign data_out = val_q;

endmodule

// File: rtl/register_file_sb.sv
// Integer register file with same-cycle write forwarding and a per-register
// busy scoreboard used by decode to stall on writes that are still in flight.
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int NREAD     = 2,
  parameter int ZERO_REG  = 1,
  parameter int SYNC_READ = 0,
  localparam int AW       = addr_w(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XLEN-1:0]       data_in,
  input  logic [AW-1:0]         sel_in,
  input  logic                  load_en,
  input  logic                  issue_en,
  input  logic [AW-1:0]         issue_sel,
  input  logic [NREAD*AW-1:0]   sel_out,
  output logic [NREAD*XLEN-1:0] data_out,
  output logic [NREAD-1:0]      busy_out,
  output logic                  stall
);

  logic [XLEN-1:0]       regs [NREGS];
  logic [NREGS-1:0]      busy_q;
  logic [NREGS-1:0]      busy_d;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_busy;

  // Storage: one register per index; the hardwired-zero slot has no cell.
  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    if (ZERO_REG != 0 && i == REG_ZERO) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_store
      logic wr_en;
      assign wr_en = load_en && (sel_in == AW'(i));
      register #(.SIZE(XLEN)) u_reg (
        .clk      (clk),
        .rst      (rst),
        .load_en  (wr_en),
        .data_in  (data_in),
        .data_out (regs[i])
      );
    end
  end

  // Read ports: zero register first, then writeback forwarding, then storage.
  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0]   sel_p;
    logic            fwd;
    logic            is_zero;
    logic [XLEN-1:0] val;
    logic            bsy;

    assign sel_p = sel_out[p*AW +: AW];

    // Port value and busy flag; a write landing this cycle unblocks the read.
    always_comb begin
      val     = '0;
      bsy     = 1'b0;
      fwd     = load_en && (sel_in == sel_p);
      is_zero = (ZERO_REG != 0) && (sel_p == AW'(REG_ZERO));
      if (is_zero)  val = '0;
      else if (fwd) val = data_in;
      else          val = regs[sel_p];
      bsy = busy_q[sel_p] && !fwd;
    end

    assign rd_data[p*XLEN +: XLEN] = val;
    assign rd_busy[p]              = bsy;
  end

  // Scoreboard next state: writeback clears, issue sets (issue wins on a tie).
  always_comb begin
    busy_d = busy_q;
    if (load_en)       busy_d[sel_in]    = 1'b0;
    if (issue_en)      busy_d[issue_sel] = 1'b1;
    if (ZERO_REG != 0) busy_d[REG_ZERO]  = 1'b0;
  end

  // Scoreboard flops; reset aborts every pending claim.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  if (SYNC_READ != 0) begin : g_sync
    logic [NREAD*XLEN-1:0] data_out_q;
    logic [NREAD*XLEN-1:0] data_out_d;
    logic [NREAD-1:0]      busy_out_q;
    logic [NREAD-1:0]      busy_out_d;

    // Registered read: data and busy share the same one-cycle latency.
    always_comb begin
      data_out_d = rd_data;
      busy_out_d = rd_busy;
    end

    // Output registers, zero while reset is asserted.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_out_q <= '0;
        busy_out_q <= '0;
      end else begin
        data_out_q <= data_out_d;
        busy_out_q <= busy_out_d;
      end
    end

    assign data_out = data_out_q;
    assign busy_out = busy_out_q;
  end else begin : g_comb
    assign data_out = rd_data;
    assign busy_out = rd_busy;
  end

  assign stall = |busy_out;

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: a combinational-read 32x32 2-port instance and a
// registered-read 16x64 4-port instance driven with the same directed steps.
module tb_register_file_sb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Shared stimulus (indices below 16 map to the same register on both DUTs).
  logic [63:0] din   = '0;
  logic [4:0]  s_in  = '0;
  logic        ld    = 1'b0;
  logic        iss   = 1'b0;
  logic [4:0]  s_iss = '0;
  logic [4:0]  s_rd [4];

  // DUT A: XLEN=32, NREGS=32, NREAD=2, ZERO_REG=1, SYNC_READ=0
  logic [9:0]  a_sel_out;
  logic [63:0] a_data_out;
  logic [1:0]  a_busy_out;
  logic        a_stall;

  // DUT B: XLEN=64, NREGS=16, NREAD=4, ZERO_REG=1, SYNC_READ=1
  logic [15:0]  b_sel_out;
  logic [255:0] b_data_out;
  logic [3:0]   b_busy_out;
  logic         b_stall;

  assign a_sel_out = {s_rd[1], s_rd[0]};
  assign b_sel_out = {s_rd[3][3:0], s_rd[2][3:0], s_rd[1][3:0], s_rd[0][3:0]};

  register_file_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(1), .SYNC_READ(0)) u_a (
    .clk(clk), .rst(rst), .data_in(din[31:0]), .sel_in(s_in), .load_en(ld),
    .issue_en(iss), .issue_sel(s_iss), .sel_out(a_sel_out), .data_out(a_data_out),
    .busy_out(a_busy_out), .stall(a_stall)
  );

  register_file_sb #(.XLEN(64), .NREGS(16), .NREAD(4), .ZERO_REG(1), .SYNC_READ(1)) u_b (
    .clk(clk), .rst(rst), .data_in(din), .sel_in(s_in[3:0]), .load_en(ld),
    .issue_en(iss), .issue_sel(s_iss[3:0]), .sel_out(b_sel_out), .data_out(b_data_out),
    .busy_out(b_busy_out), .stall(b_stall)
  );

  // Reference state built from the behaviour description.
  logic [31:0] mem_a  [32];
  logic        busy_a [32];
  logic [63:0] mem_b  [16];
  logic        busy_b [16];

  typedef struct {
    string       tag;
    int          port;   // -1 marks the stall entry
    logic [63:0] data;
    logic        bsy;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) begin mem_a[i] = '0; busy_a[i] = 1'b0; end
    for (int i = 0; i < 16; i++) begin mem_b[i] = '0; busy_b[i] = 1'b0; end
  endtask

  task automatic drv(input logic [63:0] d, input logic [4:0] si, input logic l,
                     input logic is, input logic [4:0] isel,
                     input logic [4:0] r0, input logic [4:0] r1,
                     input logic [4:0] r2, input logic [4:0] r3);
    din = d; s_in = si; ld = l; iss = is; s_iss = isel;
    s_rd[0] = r0; s_rd[1] = r1; s_rd[2] = r2; s_rd[3] = r3;
  endtask

  // One clock: predict, check A in-cycle, clock, update model, check B.
  task automatic cyc(input string tag);
    logic [63:0] e;
    logic        eb;
    logic        st;
    logic [4:0]  ia;
    logic [3:0]  ib;
    exp_t        x;
    #1;
    st = 1'b0;
    for (int p = 0; p < 2; p++) begin
      ia = s_rd[p];
      if (ia == 5'd0)              e = '0;
      else if (ld && s_in == ia)   e = {32'd0, din[31:0]};
      else                         e = {32'd0, mem_a[ia]};
      eb = busy_a[ia] && !(ld && s_in == ia);
      st = st | eb;
      qa.push_back('{$sformatf("%s_a_p%0d", tag, p), p, e, eb});
    end
    qa.push_back('{$sformatf("%s_a_stall", tag), -1, 64'd0, st});
    st = 1'b0;
    for (int p = 0; p < 4; p++) begin
      ib = s_rd[p][3:0];
      if (ib == 4'd0)                   e = '0;
      else if (ld && s_in[3:0] == ib)   e = din;
      else                              e = mem_b[ib];
      eb = busy_b[ib] && !(ld && s_in[3:0] == ib);
      st = st | eb;
      qb.push_back('{$sformatf("%s_b_p%0d", tag, p), p, e, eb});
    end
    qb.push_back('{$sformatf("%s_b_stall", tag), -1, 64'd0, st});
    while (qa.size() > 0) begin
      x = qa.pop_front();
      if (x.port < 0) chk(x.tag, 64'(a_stall), 64'(x.bsy));
      else begin
        chk({x.tag, "_data"}, {32'd0, a_data_out[x.port*32 +: 32]}, x.data);
        chk({x.tag, "_busy"}, 64'(a_busy_out[x.port]), 64'(x.bsy));
      end
    end
    @(posedge clk);
    if (ld && s_in != 5'd0) mem_a[s_in] = din[31:0];
    if (ld) busy_a[s_in] = 1'b0;
    if (iss) busy_a[s_iss] = 1'b1;
    busy_a[0] = 1'b0;
    if (ld && s_in[3:0] != 4'd0) mem_b[s_in[3:0]] = din;
    if (ld) busy_b[s_in[3:0]] = 1'b0;
    if (iss) busy_b[s_iss[3:0]] = 1'b1;
    busy_b[0] = 1'b0;
    #1;
    while (qb.size() > 0) begin
      x = qb.pop_front();
      if (x.port < 0) chk(x.tag, 64'(b_stall), 64'(x.bsy));
      else begin
        chk({x.tag, "_data"}, b_data_out[x.port*64 +: 64], x.data);
        chk({x.tag, "_busy"}, 64'(b_busy_out[x.port]), 64'(x.bsy));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int p = 0; p < 4; p++) s_rd[p] = '0;
    clear_model();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_a_data",  a_data_out, 64'd0);
    chk("rst_b_data0", b_data_out[63:0], 64'd0);
    chk("rst_a_stall", 64'(a_stall), 64'd0);
    chk("rst_b_stall", 64'(b_stall), 64'd0);
    rst = 1'b0;

    // Sweep every index on every port after reset.
    for (int i = 0; i < 32; i++) begin
      drv('0, '0, 1'b0, 1'b0, '0, 5'(i), 5'(i), 5'(i), 5'(i));
      cyc("t1_sweep");
    end

    // Write reg5, read it back next cycle; reg0 stays zero.
    drv({32'hCAFEF00D, 32'hDEADBEEF}, 5'd5, 1'b1, 1'b0, '0, 5'd1, 5'd2, 5'd3, 5'd4);
    cyc("t2_wr5");
    drv('0, '0, 1'b0, 1'b0, '0, 5'd5, 5'd0, 5'd5, 5'd0);
    cyc("t2_rd5");
    chk("t2_reg5_const", {32'd0, a_data_out[31:0]}, 64'h0000_0000_DEAD_BEEF);
    drv(64'h1234, 5'd0, 1'b1, 1'b0, '0, 5'd0, 5'd5, 5'd0, 5'd5);
    cyc("t2_wr0");
    drv('0, '0, 1'b0, 1'b0, '0, 5'd0, 5'd0, 5'd0, 5'd0);
    cyc("t2_rd0");
    chk("t2_reg0_const", a_data_out, 64'd0);

    // Forwarding: write reg7 while reading it.
    drv({32'h5A5A5A5A, 32'hA5A5A5A5}, 5'd7, 1'b1, 1'b0, '0, 5'd5, 5'd7, 5'd7, 5'd7);
    cyc("t3_fwd7");
    drv('0, '0, 1'b0, 1'b0, '0, 5'd7, 5'd7, 5'd0, 5'd5);
    cyc("t3_rd7");

    // Issue to reg3, stays busy until its writeback.
    drv('0, '0, 1'b0, 1'b1, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3);
    cyc("t4_issue3");
    drv('0, '0, 1'b0, 1'b0, '0, 5'd3, 5'd5, 5'd3, 5'd7);
    cyc("t4_busy3");
    chk("t4_stall_const", 64'(a_stall), 64'd1);
    drv(64'h0000_0003_3333_3333, 5'd3, 1'b1, 1'b0, '0, 5'd3, 5'd3, 5'd3, 5'd3);
    cyc("t4_wb3");
    drv('0, '0, 1'b0, 1'b0, '0, 5'd3, 5'd3, 5'd3, 5'd3);
    cyc("t4_free3");

    // Issue and writeback to reg9 in one cycle: value lands, busy stays.
    drv(64'h9999_0000_0000_9999, 5'd9, 1'b1, 1'b1, 5'd9, 5'd1, 5'd2, 5'd9, 5'd9);
    cyc("t5_both9");
    drv('0, '0, 1'b0, 1'b0, '0, 5'd9, 5'd9, 5'd9, 5'd9);
    cyc("t5_rd9");
    chk("t5_busy_const", 64'(a_busy_out), 64'd3);

    // Mid-cycle reset with reg4 busy.
    drv('0, '0, 1'b0, 1'b1, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0);
    cyc("t6_issue4");
    drv('0, '0, 1'b0, 1'b0, '0, 5'd4, 5'd5, 5'd4, 5'd5);
    cyc("t6_busy4");
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_a_data",  a_data_out, 64'd0);
    chk("t6_rst_a_busy",  64'(a_busy_out), 64'd0);
    chk("t6_rst_a_stall", 64'(a_stall), 64'd0);
    chk("t6_rst_b_data",  b_data_out[127:0] == 128'd0 ? 64'd0 : 64'd1, 64'd0);
    chk("t6_rst_b_busy",  64'(b_busy_out), 64'd0);
    chk("t6_rst_b_stall", 64'(b_stall), 64'd0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    drv('0, '0, 1'b0, 1'b0, '0, 5'd4, 5'd5, 5'd4, 5'd7);
    cyc("t6_after");

    // Mixed random traffic against the model.
    for (int k = 0; k < 60; k++) begin
      drv({$urandom, $urandom}, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      cyc("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
